tbu_block: RTL and testbench
============================

// Module: tbu_block
// PURPOSE
//  Block-based Viterbi traceback unit. Sits between the ACS array (survivor decisions) and the SIPO.
//  Buffers FRAME_LEN decision vectors, traces back from a start state, then re-orders the bits oldest-first.
//  Emits them as a serial burst on data_serial_o/valid_serial_o. The SIPO packs each burst into one byte.
// PARAMETERS
//  K          3  constraint length (K>=3); STATE_W=K-1, NUM_STATES=2**(K-1)
//  FRAME_LEN  8  trellis steps (decoded bits) per frame; must be a power of 2, >=2
//  TAIL_TERM  1  1: trace starts from state 0; 0: trace starts from best_state_i
// PORTS
//  clk             in   1           rising-edge clock
//  rst_n           in   1           asynchronous active-low reset
//  dec_i           in   NUM_STATES  survivor decision bit per state for current trellis step
//  dec_valid_i     in   1           dec_i/best_state_i valid this cycle
//  dec_ready_o     out  1           block can accept a decision vector
//  best_state_i    in   STATE_W     min-metric state, sampled with the last vector of a frame
//  data_serial_o   out  1           decoded bit, oldest first
//  valid_serial_o  out  1           data_serial_o valid
//  busy_o          out  1           high in TRACE or OUTPUT
// BEHAVIOUR
//  Trellis convention:
//   - state s = {newest input, ..., oldest}; next state = {u, s[STATE_W-1:1]}.
//   - Predecessor of s with decision d = {s[STATE_W-2:0], d}; decoded bit at that step = s[STATE_W-1].
//  Reset (async): state=WRITE, wr_ptr=0, dec_ready_o=1, data_serial_o=0, valid_serial_o=0, busy_o=0.
//   - Decision RAM and LIFO contents are not reset.
//  Handshake: vector accepted on an edge with dec_valid_i & dec_ready_o. dec_valid_i while ready=0 is ignored.
//  FSM:
//   - WRITE: each accept writes dec_i to mem[wr_ptr], wr_ptr++.
//     On accept with wr_ptr==FRAME_LEN-1: latch cur_state (0 if TAIL_TERM else best_state_i).
//     Then rd_ptr=FRAME_LEN-1, go to TRACE. dec_ready_o and busy_o are registered and update on that edge.
//   - TRACE: exactly FRAME_LEN cycles. Each cycle:
//     lifo[rd_ptr] <= cur_state[STATE_W-1];
//     cur_state <= {cur_state[STATE_W-2:0], mem[rd_ptr][cur_state]};
//     rd_ptr--.
//     After the step with rd_ptr==0, go to OUTPUT with out_ptr=0.
//   - OUTPUT: exactly FRAME_LEN cycles. Registered outputs: valid_serial_o=1, data_serial_o=lifo[out_ptr], out_ptr++.
//     After the last bit, go to WRITE with wr_ptr=0 and dec_ready_o=1.
//  Timing:
//   - Last accept on edge E0 -> TRACE edges E1..E_F (F=FRAME_LEN).
//   - valid_serial_o high for cycles after edges E_F+1..E_2F; low and ready=1 after edge E_2F+1.
//  Burst rules:
//   - valid_serial_o is never high outside OUTPUT. Bursts are exactly FRAME_LEN contiguous cycles with no gaps.
//   - dec_ready_o=0 for the whole of TRACE+OUTPUT (2F+1 cycles after E0).
//  Pointer widths: $clog2(FRAME_LEN); pointers wrap naturally, no overflow states.
//  Reset mid-TRACE/OUTPUT: burst aborted immediately, valid_serial_o=0, frame discarded, back to WRITE.
//  best_state_i is ignored except on the last accept when TAIL_TERM=0.
// TESTING
//  1 Reset then TAIL_TERM=1, 8 vectors dec_i=4'h0 -> 8-cycle burst of 0s, 9 cycles after last accept; ready=1 after.
//  2 Inputs 1,0,1,0,0,1,0,1 from noiseless path decisions (off-path bits random), TAIL_TERM=0, best_state_i=2
//    -> serial 1,0,1,0,0,1,0,1; downstream SIPO byte 0xA5.
//  3 Hold dec_valid_i=1 during TRACE/OUTPUT with changing dec_i -> ignored.
//    Next frame begins at mem[0]; output unaffected.
//  4 Toggle dec_valid_i every other cycle during WRITE -> exactly 8 accepts before TRACE; burst correct.
//  5 Assert rst_n=0 at 3rd OUTPUT cycle -> valid_serial_o=0 asynchronously, ready=1.
//    Next full frame decodes correctly.
//  6 Back-to-back frames 0xA5 then 0x3C -> two bursts, each exactly 8 valid cycles, no valid between bursts.

Source files
------------

// File: rtl/tbu_block.sv
// Block traceback unit for a Viterbi decoder: stores one frame of survivor
// decisions, traces back from a start state, then emits the bits oldest-first.
module tbu_block #(
  parameter int K         = 3,
  parameter int FRAME_LEN = 8,
  parameter int TAIL_TERM = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2**(K-1)-1:0]   dec_i,
  input  logic                  dec_valid_i,
  output logic                  dec_ready_o,
  input  logic [K-2:0]          best_state_i,
  output logic                  data_serial_o,
  output logic                  valid_serial_o,
  output logic                  busy_o
);

  localparam int STATE_W    = K - 1;
  localparam int NUM_STATES = 2 ** STATE_W;
  localparam int PTR_W      = $clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_WRITE,
    ST_TRACE,
    ST_OUTPUT
  } state_t;

  state_t               state_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W-1:0]     out_ptr_reg;
  logic [STATE_W-1:0]   cur_state_reg;

  logic [NUM_STATES-1:0] mem  [FRAME_LEN];
  logic                  lifo [FRAME_LEN];

  logic accept;
  logic dec_bit;

  assign accept  = dec_valid_i & dec_ready_o;
  assign dec_bit = mem[rd_ptr_reg][cur_state_reg];

  // Storage arrays carry no reset so they can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (state_reg == ST_WRITE && accept) begin
      mem[wr_ptr_reg] <= dec_i;
    end
    if (state_reg == ST_TRACE) begin
      lifo[rd_ptr_reg] <= cur_state_reg[STATE_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_WRITE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      out_ptr_reg    <= '0;
      cur_state_reg  <= '0;
      dec_ready_o    <= 1'b1;
      busy_o         <= 1'b0;
      valid_serial_o <= 1'b0;
      data_serial_o  <= 1'b0;
    end else begin
      case (state_reg)
        ST_WRITE: begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == LAST_PTR) begin
              cur_state_reg <= (TAIL_TERM != 0) ? '0 : best_state_i;
              rd_ptr_reg    <= LAST_PTR;
              dec_ready_o   <= 1'b0;
              busy_o        <= 1'b1;
              state_reg     <= ST_TRACE;
            end
          end
        end

        ST_TRACE: begin
          // Step back to the predecessor selected by the stored decision.
          cur_state_reg <= {cur_state_reg[STATE_W-2:0], dec_bit};
          rd_ptr_reg    <= rd_ptr_reg - 1'b1;
          if (rd_ptr_reg == '0) begin
            out_ptr_reg <= '0;
            state_reg   <= ST_OUTPUT;
          end
        end

        ST_OUTPUT: begin
          // out_ptr wraps to 0 after the last bit; valid then marks completion.
          if (valid_serial_o && out_ptr_reg == '0) begin
            valid_serial_o <= 1'b0;
            wr_ptr_reg     <= '0;
            dec_ready_o    <= 1'b1;
            busy_o         <= 1'b0;
            state_reg      <= ST_WRITE;
          end else begin
            valid_serial_o <= 1'b1;
            data_serial_o  <= lifo[out_ptr_reg];
            out_ptr_reg    <= out_ptr_reg + 1'b1;
          end
        end

        default: state_reg <= ST_WRITE;
      endcase
    end
  end

endmodule

// File: tb/tb_tbu_block.sv
// Scoreboard bench for tbu_block: one instance per tail mode sharing stimulus,
// frames built from an encoder path model with random off-path decisions.
module tb_tbu_block;

  localparam int K  = 3;
  localparam int F  = 8;
  localparam int NS = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NS-1:0] dec_i = '0;
  logic          dec_valid_i = 1'b0;
  logic [SW-1:0] best_state_i = '0;

  logic rdy_a, dat_a, val_a, busy_a;
  logic rdy_b, dat_b, val_b, busy_b;

  always #5 clk = ~clk;

  tbu_block #(.K(K), .FRAME_LEN(F), .TAIL_TERM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .dec_i(dec_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(rdy_a), .best_state_i(best_state_i),
    .data_serial_o(dat_a), .valid_serial_o(val_a), .busy_o(busy_a)
  );

  tbu_block #(.K(K), .FRAME_LEN(F), .TAIL_TERM(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .dec_i(dec_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(rdy_b), .best_state_i(best_state_i),
    .data_serial_o(dat_b), .valid_serial_o(val_b), .busy_o(busy_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int exp_a[$];
  int exp_b[$];
  int run_len[2];
  logic [7:0] shf[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor for one lane; expected value 2 means "not checked".
  task automatic mon(input int i, input logic v, input logic d, input logic r, input logic bz);
    int  e;
    bit  has;
    if (v === 1'b1) begin
      if (run_len[i] == 0) chk($sformatf("latency_%0d", i), cyc - last_acc, F + 1);
      run_len[i]++;
      chk($sformatf("ready_in_burst_%0d", i), r, 0);
      chk($sformatf("busy_in_burst_%0d", i), bz, 1);
      e = 2;
      if (i == 0) begin
        has = exp_a.size() > 0;
        if (has) e = exp_a.pop_front();
      end else begin
        has = exp_b.size() > 0;
        if (has) e = exp_b.pop_front();
      end
      chk($sformatf("expected_bit_present_%0d", i), has, 1);
      if (e != 2) chk($sformatf("bit_%0d", i), d, e[0]);
      shf[i] = {shf[i][6:0], d};
    end else if (run_len[i] != 0) begin
      chk($sformatf("burst_len_%0d", i), run_len[i], F);
      chk($sformatf("ready_after_burst_%0d", i), r, 1);
      $display("burst dut%0d bits=%0d byte=%h", i, run_len[i], shf[i]);
      run_len[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    run_len[0] = 0;
    run_len[1] = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        mon(0, val_a, dat_a, rdy_a, busy_a);
        mon(1, val_b, dat_b, rdy_b, busy_b);
      end else begin
        run_len[0] = 0;
        run_len[1] = 0;
      end
    end
  end

  function automatic logic [1:0] final_state(input logic [7:0] b);
    return {b[0], b[1]};
  endfunction

  task automatic send_vec(input logic [NS-1:0] d, input logic [SW-1:0] bs);
    int n = 0;
    @(negedge clk);
    dec_i = d;
    best_state_i = bs;
    dec_valid_i = 1'b1;
    while (rdy_b !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 200, 1);
    last_acc = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    dec_valid_i = 1'b0;
    dec_i = NS'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [SW-1:0] bs,
                            input bit ca, input bit cb, input bit gaps);
    logic [SW-1:0] s;
    logic [SW-1:0] sn;
    logic [NS-1:0] d;
    logic          u;
    s = SW'($urandom);
    for (int t = 0; t < F; t++) begin
      exp_a.push_back(ca ? int'(b[7-t]) : 2);
      exp_b.push_back(cb ? int'(b[7-t]) : 2);
    end
    for (int t = 0; t < F; t++) begin
      u  = b[7-t];
      sn = {u, s[1]};
      d  = NS'($urandom);
      d[sn] = s[0];
      send_vec(d, (t == F - 1) ? bs : SW'($urandom));
      s = sn;
      if (gaps && t < F - 1) idle();
    end
    idle();
    $display("frame sent byte=%h best_state=%0d gaps=%0d", b, bs, gaps);
  endtask

  task automatic junk_while_busy();
    int n = 0;
    @(negedge clk);
    while (rdy_b !== 1'b1 && n < 200) begin
      dec_valid_i = 1'b1;
      dec_i = NS'($urandom);
      @(negedge clk);
      n++;
    end
    dec_valid_i = 1'b0;
    chk("junk_timeout", n < 200, 1);
  endtask

  initial begin
    int n;
    shf[0] = '0;
    shf[1] = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready_a", rdy_a, 1);
    chk("rst_valid_a", val_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_data_a", dat_a, 0);
    chk("rst_ready_b", rdy_b, 1);
    chk("rst_valid_b", val_b, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_data_b", dat_b, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // All-zero decisions trace to all-zero bits from state 0.
    for (int t = 0; t < F; t++) begin
      exp_a.push_back(0);
      exp_b.push_back(0);
    end
    for (int t = 0; t < F; t++) send_vec('0, '0);
    idle();
    $display("frame sent byte=00 zero decisions");

    send_frame(8'hA5, 2'd2, 1'b0, 1'b1, 1'b0);
    junk_while_busy();
    send_frame(8'h3C, final_state(8'h3C), 1'b1, 1'b1, 1'b0);
    send_frame(8'h5A, final_state(8'h5A), 1'b0, 1'b1, 1'b1);
    // Final state 0 but a misleading best_state: only the tail-terminated unit is checked.
    send_frame(8'hF0, 2'd1, 1'b1, 1'b0, 1'b0);

    // Abort a burst with reset on its third output cycle.
    send_frame(8'hC3, final_state(8'hC3), 1'b0, 1'b1, 1'b0);
    n = 0;
    while (val_b !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("burst_start_timeout", n < 200, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid_a", val_a, 0);
    chk("abort_valid_b", val_b, 0);
    chk("abort_ready_b", rdy_b, 1);
    chk("abort_busy_b", busy_b, 0);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset applied mid-burst");

    send_frame(8'h96, final_state(8'h96), 1'b0, 1'b1, 1'b0);
    send_frame(8'hA5, final_state(8'hA5), 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, final_state(8'h3C), 1'b1, 1'b1, 1'b0);

    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || run_len[0] != 0 || run_len[1] != 0)
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 500, 1);
    chk("queue_a_empty", exp_a.size(), 0);
    chk("queue_b_empty", exp_b.size(), 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
